// File: rtl/fib_share_arb.sv
// Round-robin arbiter sharing one Fibonacci engine among NREQ requesters.
// Optional watchdog abort of a stuck engine: define FIB_ARB_TIMEOUT_EN.
module fib_share_arb #(
   parameter int NREQ = 4,
   parameter int IW   = 5,
   parameter int FW   = 16,
   parameter int TMO  = 63
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*IW-1:0] req_idx,
   output logic [NREQ-1:0]    ack,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [FW-1:0]      rsp_data,
   output logic               busy,
   output logic               timeout_err,
   output logic               fib_start,
   output logic [IW-1:0]      fib_i,
   input  logic               fib_ready,
   input  logic               fib_done_tick,
   input  logic [FW-1:0]      fib_f
);

   localparam int PW = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t         state;
   logic [PW-1:0]  ptr;
   logic [PW-1:0]  gnt;
   logic [PW-1:0]  win;
   logic           win_vld;
   int unsigned    cand;

`ifdef FIB_ARB_TIMEOUT_EN
   logic [7:0]     tmo_cnt;
   logic           tmo_err_q;
   assign timeout_err = tmo_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   // First asserted request at or after the rotating pointer, wrapping.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      cand    = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = (32'(ptr) + k) % 32'(NREQ);
         if (!win_vld && req[PW'(cand)]) begin
            win_vld = 1'b1;
            win     = PW'(cand);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         ptr       <= '0;
         gnt       <= '0;
         fib_i     <= '0;
         rsp_data  <= '0;
         ack       <= '0;
         rsp_valid <= '0;
         fib_start <= 1'b0;
         busy      <= 1'b0;
`ifdef FIB_ARB_TIMEOUT_EN
         tmo_cnt   <= '0;
         tmo_err_q <= 1'b0;
`endif
      end else begin
         ack       <= '0;
         rsp_valid <= '0;
         fib_start <= 1'b0;
`ifdef FIB_ARB_TIMEOUT_EN
         tmo_err_q <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (win_vld && fib_ready) begin
                  gnt       <= win;
                  fib_i     <= req_idx[win*IW +: IW];
                  ack       <= NREQ'(1) << win;
                  fib_start <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
`ifdef FIB_ARB_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
               state <= WAIT;
            end
            WAIT: begin
               if (fib_done_tick) begin
                  rsp_data  <= fib_f;
                  rsp_valid <= NREQ'(1) << gnt;
                  state     <= RESP;
               end
`ifdef FIB_ARB_TIMEOUT_EN
               // TMO-1 compare: the counter reads 0 in the first WAIT cycle.
               else if (tmo_cnt == 8'(TMO - 1)) begin
                  rsp_data  <= '0;
                  rsp_valid <= NREQ'(1) << gnt;
                  tmo_err_q <= 1'b1;
                  state     <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
`endif
            end
            RESP: begin
               ptr   <= (gnt == PW'(NREQ - 1)) ? '0 : gnt + 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fib_share_arb.sv
// Directed bench for fib_share_arb with a behavioural engine stub and
// scoreboard queues for expected grants and responses.
module tb_fib_share_arb;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  req;
   logic [19:0] req_idx;
   logic [3:0]  ack;
   logic [3:0]  rsp_valid;
   logic [15:0] rsp_data;
   logic        busy;
   logic        timeout_err;
   logic        fib_start;
   logic [4:0]  fib_i;
   logic        fib_ready;
   logic        fib_done_tick;
   logic [15:0] fib_f;

   fib_share_arb dut (
      .clk(clk), .reset_n(reset_n), .req(req), .req_idx(req_idx),
      .ack(ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
      .timeout_err(timeout_err), .fib_start(fib_start), .fib_i(fib_i),
      .fib_ready(fib_ready), .fib_done_tick(fib_done_tick), .fib_f(fib_f)
   );

   always #5 clk = ~clk;

   // engine stub: latency 4+i cycles, optional hold (not ready) and mute (never done)
   logic        eng_busy, eng_hold, eng_mute;
   logic [4:0]  eng_i;
   int unsigned eng_cnt;
   assign fib_ready = !eng_busy && !eng_hold;

   function automatic logic [15:0] fib16(input logic [4:0] n);
      logic [15:0] a, b, t;
      a = 16'd0; b = 16'd1;
      for (int i = 0; i < int'(n); i++) begin
         t = a + b; a = b; b = t;
      end
      return a;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         eng_busy <= 1'b0; fib_done_tick <= 1'b0; fib_f <= '0; eng_cnt <= 0; eng_i <= '0;
      end else begin
         fib_done_tick <= 1'b0;
         if (fib_start && fib_ready) begin
            eng_busy <= 1'b1; eng_i <= fib_i; eng_cnt <= 4 + int'(fib_i);
         end else if (eng_busy && !eng_mute) begin
            if (eng_cnt == 0) begin
               eng_busy <= 1'b0; fib_done_tick <= 1'b1; fib_f <= fib16(eng_i);
            end else eng_cnt <= eng_cnt - 1;
         end
      end
   end

   typedef struct { int unsigned k; logic [4:0] idx; } ack_t;
   typedef struct { int unsigned k; logic [15:0] d; logic t; } rsp_t;
   ack_t aq[$];
   rsp_t rq[$];
   ack_t a_e;
   rsp_t r_e;
   int   total = 0;
   int   bad = 0;
   int   ack_cnt = 0;
   logic prev_done = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (reset_n) begin
         if (ack !== 4'b0) begin
            if (aq.size() == 0) chk("ack_unexpected", 32'(ack), 32'd0);
            else begin
               a_e = aq.pop_front();
               chk("ack_onehot", 32'(ack), 32'd1 << a_e.k);
               chk("fib_start", 32'(fib_start), 32'd1);
               chk("fib_i", 32'(fib_i), 32'(a_e.idx));
               chk("busy_issue", 32'(busy), 32'd1);
               ack_cnt++;
            end
         end
         if (rsp_valid !== 4'b0) begin
            if (rq.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            else begin
               r_e = rq.pop_front();
               chk("rsp_onehot", 32'(rsp_valid), 32'd1 << r_e.k);
               chk("rsp_data", 32'(rsp_data), 32'(r_e.d));
               chk("timeout_err", 32'(timeout_err), 32'(r_e.t));
               if (!r_e.t) chk("done_to_rsp", 32'(prev_done), 32'd1);
            end
         end
      end
      prev_done = fib_done_tick;
   end

   task automatic set_idx(input int k, input logic [4:0] v);
      req_idx[k*5 +: 5] = v;
   endtask

   task automatic push(input int unsigned k, input logic [4:0] idx, input logic [15:0] d);
      aq.push_back('{k, idx});
      rq.push_back('{k, d, 1'b0});
   endtask

   // raise mask, wait for n grants; drop each bit on its ack unless hold
   task automatic run(input logic [3:0] mask, input int n, input bit hold);
      int target;
      target = ack_cnt + n;
      req = req | mask;
      for (int c = 0; c < 400 && ack_cnt < target; c++) begin
         @(negedge clk); #1;
         if (!hold) req = req & ~ack;
      end
      if (ack_cnt < target) chk("ack_wait", 32'(ack_cnt), 32'(target));
      req = req & ~mask;
   endtask

   task automatic drain();
      for (int c = 0; c < 400 && (rq.size() + aq.size()) != 0; c++) begin
         @(negedge clk); #1;
      end
      chk("drain", 32'(rq.size() + aq.size()), 32'd0);
      @(negedge clk); #1;
   endtask

   task automatic txn(input int unsigned k, input logic [4:0] idx, input logic [15:0] d);
      set_idx(int'(k), idx);
      push(k, idx, d);
      run(4'b1 << k, 1, 1'b0);
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      reset_n = 1'b0; req = '0; req_idx = '0;
      eng_hold = 1'b0; eng_mute = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fib_start", 32'(fib_start), 32'd0);
      chk("rst_fib_i", 32'(fib_i), 32'd0);
      chk("rst_timeout", 32'(timeout_err), 32'd0);
      reset_n = 1'b1;

      // single request, explicit one-cycle req->ack latency
      set_idx(0, 5'd10);
      push(0, 5'd10, 16'd55);
      @(posedge clk); #1 req = 4'b0001;
      @(negedge clk); #1 chk("ack_early", 32'(ack), 32'd0);
      @(negedge clk); #1 chk("ack_latency", 32'(ack), 32'b0001);
      req = '0;
      drain();

      // engine not ready: stall with no grant
      eng_hold = 1'b1;
      set_idx(0, 5'd7);
      push(0, 5'd7, 16'd13);
      req = 4'b0001;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1 chk("stall_busy", 32'(busy), 32'd0);
      end
      eng_hold = 1'b0;
      run(4'b0001, 1, 1'b0);
      drain();

      // index boundaries, including 16-bit truncation of fib(25)
      txn(0, 5'd0, 16'd0);
      txn(1, 5'd1, 16'd1);
      txn(2, 5'd24, 16'd46368);
      txn(3, 5'd25, 16'd9489);

      // all four held high from pointer 0
      set_idx(0, 5'd3); set_idx(1, 5'd4); set_idx(2, 5'd5); set_idx(3, 5'd6);
      push(0, 5'd3, 16'd2); push(1, 5'd4, 16'd3);
      push(2, 5'd5, 16'd5); push(3, 5'd6, 16'd8);
      push(0, 5'd3, 16'd2);
      run(4'b1111, 5, 1'b1);
      drain();

      // pointer wrap after a grant to 3
      txn(3, 5'd2, 16'd1);
      set_idx(1, 5'd9); set_idx(3, 5'd11);
      push(1, 5'd9, 16'd34); push(3, 5'd11, 16'd89);
      run(4'b1010, 2, 1'b0);
      drain();
      // pointer at 2 must prefer 3 over 0
      txn(1, 5'd12, 16'd144);
      set_idx(0, 5'd13); set_idx(3, 5'd14);
      push(3, 5'd14, 16'd377); push(0, 5'd13, 16'd233);
      run(4'b1001, 2, 1'b0);
      drain();

      // reset during WAIT aborts without a response
      set_idx(2, 5'd20);
      aq.push_back('{2, 5'd20});
      run(4'b0100, 1, 1'b0);
      repeat (3) @(negedge clk);
      #1 reset_n = 1'b0;
      #1 chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_rsp", 32'(rsp_valid), 32'd0);
      repeat (2) @(negedge clk);
      #1 reset_n = 1'b1;
      repeat (40) @(negedge clk);
      #1 chk("rst_mid_idle", 32'(busy), 32'd0);
      txn(1, 5'd15, 16'd610);

`ifdef FIB_ARB_TIMEOUT_EN
      // engine never completes: watchdog response with zero data
      eng_mute = 1'b1;
      set_idx(0, 5'd5);
      aq.push_back('{0, 5'd5});
      rq.push_back('{0, 16'd0, 1'b1});
      run(4'b0001, 1, 1'b0);
      drain();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
